ifm_pingpong_buffer: RTL and testbench
======================================

# ifm_pingpong_buffer

Double-buffered (ping-pong) input-feature-map buffer, successor to the single-bank IFM BRAM. It provides two independent block-RAM banks, so the DMA/loader side can fill one bank while the PE array streams the other. Bank ownership is handed over with `last` strobes and exposed via ready flags. Sits between the IFM loader and the convolution datapath's IFM read port.

## Interface
- DATA_WIDTH, 32, word width of each bank entry
- DEPTH, 1024, entries per bank; power of two, ≥ 2
- ADDR_W, $clog2(DEPTH), bank word-address width
- RD_SHIFT, 2, right shift applied to `rd_addr` (byte-to-word style addressing); 0 allowed

- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  word address within current write bank
- wr_data  in  DATA_WIDTH  write data
- wr_last  in  1  with accepted write: final word, hand bank to reader
- wr_ready  out  1  current write bank is free (= !full[wp])
- rd_en  in  1  read request
- rd_addr  in  ADDR_W+RD_SHIFT  read address; word index = rd_addr >> RD_SHIFT
- rd_last  in  1  with accepted read: final read, release bank to writer
- rd_ready  out  1  current read bank is full (= full[rp])
- rd_data  out  DATA_WIDTH  read data, registered
- rd_valid  out  1  rd_data holds data of read accepted previous cycle
- wr_bank  out  1  index of bank being written (wp)
- rd_bank  out  1  index of bank being read (rp)
- full_cnt  out  2  number of full banks, 0..2
- err_wr  out  1  sticky: write attempted while !wr_ready
- err_rd  out  1  sticky: read attempted while !rd_ready

## Operation
- State: bank memories mem0/mem1 (`ram_style = "block"`, not reset), flags full[1:0], pointers wp, rp.
- Write accepted = wr_en & wr_ready: mem[wp][wr_addr] <= wr_data. If also wr_last: full[wp] <= 1, wp <= ~wp.
- wr_en & !wr_ready: write dropped, memory unchanged, err_wr <= 1.
- Read accepted = rd_en & rd_ready: rd_data <= mem[rp][rd_addr >> RD_SHIFT], rd_valid <= 1. If also rd_last: full[rp] <= 0, rp <= ~rp.
- rd_en & !rd_ready: rd_valid <= 0, rd_data holds, err_rd <= 1. No rd_en: rd_valid <= 0, rd_data holds.
- wr_last without wr_en, or rd_last without rd_en: ignored.
- Same-cycle wr_last (bank wp) and rd_last (bank rp): both applied independently; when wp == rp (both banks in transit case) the write sets and the read clears distinct flags only if banks differ. When wp == rp, the two flags cannot both be legal (wr_ready requires !full, rd_ready requires full), so at most one applies.
- full_cnt = full[0] + full[1], combinational from flags.
- err flags clear only on reset.
- Bank contents survive hand-over; reader sees exactly the last values written before wr_last.

## Timing
- Reset (async assert, sync-safe deassert): full = 00, wp = rp = 0, rd_data = 0, rd_valid = 0, err_wr = err_rd = 0; hence wr_ready = 1, rd_ready = 0, full_cnt = 0, wr_bank = rd_bank = 0.
- Read latency 1 cycle: data for read accepted at edge N valid after edge N (sampled at N+1).
- Write-to-read: write at edge N visible to a read at edge N+1 or later; wr_last at edge N makes rd_ready = 1 after edge N.
- rd_last at edge N makes wr_ready for that bank 1 after edge N; the read at edge N still returns valid data.
- Full back-to-back throughput: one write and one read every cycle when both banks alternate.
- Reset mid-operation: all banks empty, in-flight rd_valid dropped; memory contents undefined to users.

## Test plan
- Reset then write bank0 addr 0..3 = 0xA0..0xA3, wr_last on addr 3 -> wr_bank=1, rd_ready=1, full_cnt=1; read rd_addr 0,4,8,12 (RD_SHIFT=2) -> rd_data 0xA0..0xA3 one cycle later, rd_valid=1 each.
- Ping-pong: fill bank1 (0xB*) while reading bank0 with rd_last on final read -> rd_bank=1, next reads return 0xB*, no stalls, no error flags.
- Overflow: fill both banks (full_cnt=2, wr_ready=0), issue write 0xDEAD -> err_wr=1, bank contents unchanged on readback.
- Underflow: after reset, rd_en -> rd_valid=0, rd_data=0, err_rd=1.
- Simultaneous: bank0 full, writing bank1; same cycle wr_last on bank1 and rd_last on bank0 -> full=10, wp=0, rp=1, full_cnt=1.
- Async reset asserted mid-stream with full_cnt=2 -> immediately rd_valid=0, wr_ready=1, rd_ready=0, errors cleared.

Source files
------------

// File: rtl/ifm_pingpong_buffer_if.sv
// Loader/reader-facing bus of the ping-pong IFM buffer.
// The master side drives requests; the slave side is the buffer itself.
interface ifm_pingpong_buffer_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned RD_SHIFT   = 2
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic                       wr_en;
    logic [ADDR_W-1:0]          wr_addr;
    logic [DATA_WIDTH-1:0]      wr_data;
    logic                       wr_last;
    logic                       wr_ready;
    logic                       rd_en;
    logic [ADDR_W+RD_SHIFT-1:0] rd_addr;
    logic                       rd_last;
    logic                       rd_ready;
    logic [DATA_WIDTH-1:0]      rd_data;
    logic                       rd_valid;
    logic                       wr_bank;
    logic                       rd_bank;
    logic [1:0]                 full_cnt;
    logic                       err_wr;
    logic                       err_rd;

    modport master (
        output wr_en, wr_addr, wr_data, wr_last, rd_en, rd_addr, rd_last,
        input  wr_ready, rd_ready, rd_data, rd_valid, wr_bank, rd_bank, full_cnt, err_wr, err_rd
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_last, rd_en, rd_addr, rd_last,
        output wr_ready, rd_ready, rd_data, rd_valid, wr_bank, rd_bank, full_cnt, err_wr, err_rd
    );
endinterface

// File: rtl/ifm_pingpong_buffer.sv
// Double-buffered IFM storage: the loader fills one bank while the PE array
// streams the other. Ownership moves between sides on accepted last strobes.
module ifm_pingpong_buffer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned RD_SHIFT   = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    ifm_pingpong_buffer_if.slave bus
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem0 [DEPTH];
    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem1 [DEPTH];

    logic [1:0]            full_q, full_d;
    logic                  wp_q, wp_d;
    logic                  rp_q, rp_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  err_wr_q, err_wr_d;
    logic                  err_rd_q, err_rd_d;
    logic [DATA_WIDTH-1:0] rd_data_q;

    logic              wr_ready;
    logic              rd_ready;
    logic              wr_acc;
    logic              rd_acc;
    logic [ADDR_W-1:0] rd_word;

    assign wr_ready = ~full_q[wp_q];
    assign rd_ready = full_q[rp_q];
    assign wr_acc   = bus.wr_en & wr_ready;
    assign rd_acc   = bus.rd_en & rd_ready;
    // Low RD_SHIFT bits of the read address are a byte offset and ignored.
    assign rd_word  = ADDR_W'(bus.rd_addr >> RD_SHIFT);

    // Next-state for bank flags, pointers, and sticky error flags.
    always_comb begin
        full_d     = full_q;
        wp_d       = wp_q;
        rp_d       = rp_q;
        rd_valid_d = rd_acc;
        err_wr_d   = err_wr_q | (bus.wr_en & ~wr_ready);
        err_rd_d   = err_rd_q | (bus.rd_en & ~rd_ready);
        // When wp == rp only one of the two can be accepted, so the updates never collide.
        if (wr_acc && bus.wr_last) begin
            full_d[wp_q] = 1'b1;
            wp_d         = ~wp_q;
        end
        if (rd_acc && bus.rd_last) begin
            full_d[rp_q] = 1'b0;
            rp_d         = ~rp_q;
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q     <= 2'b00;
            wp_q       <= 1'b0;
            rp_q       <= 1'b0;
            rd_valid_q <= 1'b0;
            err_wr_q   <= 1'b0;
            err_rd_q   <= 1'b0;
        end else begin
            full_q     <= full_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            rd_valid_q <= rd_valid_d;
            err_wr_q   <= err_wr_d;
            err_rd_q   <= err_rd_d;
        end
    end

    // Bank 0 write port (contents are not reset).
    always_ff @(posedge clk) begin
        if (wr_acc && !wp_q) mem0[bus.wr_addr] <= bus.wr_data;
    end

    // Bank 1 write port (contents are not reset).
    always_ff @(posedge clk) begin
        if (wr_acc && wp_q) mem1[bus.wr_addr] <= bus.wr_data;
    end

    // Registered read data; holds its value when no read is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_acc) begin
            rd_data_q <= rp_q ? mem1[rd_word] : mem0[rd_word];
        end
    end

    assign bus.wr_ready = wr_ready;
    assign bus.rd_ready = rd_ready;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.wr_bank  = wp_q;
    assign bus.rd_bank  = rp_q;
    assign bus.full_cnt = {1'b0, full_q[0]} + {1'b0, full_q[1]};
    assign bus.err_wr   = err_wr_q;
    assign bus.err_rd   = err_rd_q;
endmodule

// File: tb/tb_ifm_pingpong_buffer.sv
// Directed bench for the ping-pong IFM buffer; read data checked via a scoreboard queue.
module tb_ifm_pingpong_buffer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_fail = 0;
    logic [31:0] exp_q [$];

    ifm_pingpong_buffer_if #(.DATA_WIDTH(32), .DEPTH(1024), .RD_SHIFT(2)) bus ();

    ifm_pingpong_buffer #(.DATA_WIDTH(32), .DEPTH(1024), .RD_SHIFT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.wr_last = 1'b0;
        bus.rd_en   = 1'b0;
        bus.rd_addr = '0;
        bus.rd_last = 1'b0;
    endtask

    // One clock of stimulus; racc says whether the read should be accepted.
    task automatic cyc(input int we, input int wa, input logic [31:0] wd, input int wl,
                       input int re, input int ra, input int rl,
                       input int racc, input logic [31:0] rexp);
        logic [31:0] e;
        bus.wr_en   = (we != 0);
        bus.wr_addr = 10'(wa);
        bus.wr_data = wd;
        bus.wr_last = (wl != 0);
        bus.rd_en   = (re != 0);
        bus.rd_addr = 12'(ra);
        bus.rd_last = (rl != 0);
        if (racc != 0) exp_q.push_back(rexp);
        @(posedge clk);
        #1;
        idle_inputs();
        if (racc != 0) begin
            chk("rd_valid", 32'(bus.rd_valid), 32'h1);
            e = exp_q.pop_front();
            chk("rd_data", bus.rd_data, e);
        end else begin
            chk("rd_valid_low", 32'(bus.rd_valid), 32'h0);
        end
    endtask

    task automatic chk_flags(input string tag, input int wb, input int rb, input int fc,
                             input int wrdy, input int rrdy);
        chk({tag, ".wr_bank"}, 32'(bus.wr_bank), 32'(wb));
        chk({tag, ".rd_bank"}, 32'(bus.rd_bank), 32'(rb));
        chk({tag, ".full_cnt"}, 32'(bus.full_cnt), 32'(fc));
        chk({tag, ".wr_ready"}, 32'(bus.wr_ready), 32'(wrdy));
        chk({tag, ".rd_ready"}, 32'(bus.rd_ready), 32'(rrdy));
    endtask

    initial begin
        idle_inputs();
        // Reset state
        #12;
        chk_flags("reset", 0, 0, 0, 1, 0);
        chk("reset.rd_valid", 32'(bus.rd_valid), 32'h0);
        chk("reset.rd_data", bus.rd_data, 32'h0);
        chk("reset.err_wr", 32'(bus.err_wr), 32'h0);
        chk("reset.err_rd", 32'(bus.err_rd), 32'h0);
        rst_n = 1'b1;

        // Underflow: read with nothing full
        cyc(0, 0, 32'h0, 0, 1, 0, 0, 0, 32'h0);
        chk("underflow.rd_data", bus.rd_data, 32'h0);
        chk("underflow.err_rd", 32'(bus.err_rd), 32'h1);
        chk("underflow.err_wr", 32'(bus.err_wr), 32'h0);
        rst_n = 1'b0;
        #2;
        chk("rst2.err_rd", 32'(bus.err_rd), 32'h0);
        rst_n = 1'b1;

        // Fill bank0 with A0..A3
        for (int i = 0; i < 4; i++) cyc(1, i, 32'hA0 + 32'(i), (i == 3) ? 1 : 0, 0, 0, 0, 0, 0);
        chk_flags("fill0", 1, 0, 1, 1, 1);

        // Ping-pong: fill bank1 while draining bank0; byte-offset bits in rd_addr ignored
        for (int i = 0; i < 4; i++)
            cyc(1, i, 32'hB0 + 32'(i), (i == 3) ? 1 : 0, 1, 4 * i + i, (i == 3) ? 1 : 0,
                1, 32'hA0 + 32'(i));
        chk_flags("pingpong", 0, 1, 1, 1, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("hold.rd_data", bus.rd_data, 32'hA3);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 4 * i, 0, 1, 32'hB0 + 32'(i));
        chk("pingpong.err_wr", 32'(bus.err_wr), 32'h0);
        chk("pingpong.err_rd", 32'(bus.err_rd), 32'h0);

        // Same-cycle wr_last on bank0 and rd_last on bank1
        for (int i = 0; i < 3; i++) cyc(1, i, 32'hC0 + 32'(i), 0, 0, 0, 0, 0, 0);
        cyc(1, 3, 32'hC3, 1, 1, 0, 1, 1, 32'hB0);
        chk_flags("simul_a", 1, 0, 1, 1, 1);

        // Overflow: fill bank1, then both banks full
        for (int i = 0; i < 4; i++) cyc(1, i, 32'hD0 + 32'(i), (i == 3) ? 1 : 0, 0, 0, 0, 0, 0);
        chk_flags("both_full", 0, 0, 2, 0, 1);
        chk("both_full.err_wr", 32'(bus.err_wr), 32'h0);
        cyc(1, 0, 32'hDEAD, 1, 0, 0, 0, 0, 0);
        chk("overflow.err_wr", 32'(bus.err_wr), 32'h1);
        chk_flags("overflow", 0, 0, 2, 0, 1);
        for (int i = 0; i < 4; i++)
            cyc(0, 0, 0, 0, 1, 4 * i, (i == 3) ? 1 : 0, 1, 32'hC0 + 32'(i));
        chk_flags("drain0", 0, 1, 1, 1, 1);
        cyc(0, 0, 0, 0, 1, 0, 0, 1, 32'hD0);
        chk("overflow.err_rd", 32'(bus.err_rd), 32'h0);
        chk("sticky.err_wr", 32'(bus.err_wr), 32'h1);

        // Mid-stream async reset with both banks full and a read in flight
        cyc(1, 0, 32'hE0, 1, 1, 4, 0, 1, 32'hD1);
        chk("pre_rst.full_cnt", 32'(bus.full_cnt), 32'h2);
        rst_n = 1'b0;
        #1;
        chk_flags("midrst", 0, 0, 0, 1, 0);
        chk("midrst.rd_valid", 32'(bus.rd_valid), 32'h0);
        chk("midrst.err_wr", 32'(bus.err_wr), 32'h0);
        chk("midrst.err_rd", 32'(bus.err_rd), 32'h0);
        #3;
        rst_n = 1'b1;
        exp_q.delete();

        // Bank0 full, writing bank1; simultaneous wr_last and rd_last
        cyc(1, 0, 32'hF0, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 32'hF1, 1, 1, 0, 1, 1, 32'hF0);
        chk_flags("simul_b", 0, 1, 1, 1, 1);
        cyc(0, 0, 0, 0, 1, 3, 1, 1, 32'hF1);
        chk_flags("final", 0, 0, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
